// File: rtl/clkgen_multi_if.sv
// Control/status bundle for clkgen_multi: divisor programming, run/halt/step
// control in, per-channel enables and square waves out.
interface clkgen_multi_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16,
  parameter int unsigned CHW = 2
) ();
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [1:0]     mode;
  logic [NCH-1:0] gate_mask;
  logic           step_req;
  logic [NCH-1:0] ce;
  logic [NCH-1:0] sq;
  logic           step_done;

  modport master (
    output cfg_we, cfg_ch, cfg_div, mode, gate_mask, step_req,
    input  ce, sq, step_done
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, mode, gate_mask, step_req,
    output ce, sq, step_done
  );
endinterface

// File: rtl/clkgen_multi.sv
// Multi-channel clock-enable generator with per-channel programmable divisors
// and run/halt/single-step control of the gated channels.
module clkgen_multi #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 16,
  parameter int unsigned DIV_RST = 0,
  parameter int unsigned CHW     = 2
) (
  input  logic          clk,
  input  logic          rst,
  clkgen_multi_if.slave bus
);

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [CW-1:0]  div_q [NCH];
  logic [CW-1:0]  div_d [NCH];
  logic [NCH-1:0] ce_q, ce_d;
  logic [NCH-1:0] sq_q, sq_d;
  logic [NCH-1:0] tc, stepped;
  logic           step_done_q, step_done_d;
  logic           step_q;
  logic           step_edge;

  always_comb begin
    step_edge = bus.step_req & ~step_q;
    stepped   = '0;
    tc        = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      div_d[i] = div_q[i];
      ce_d[i]  = 1'b0;
      sq_d[i]  = sq_q[i];
      tc[i]    = (cnt_q[i] == div_q[i]);
      // A divisor write beats both terminal count and a step on its channel.
      if (bus.cfg_we && (bus.cfg_ch == CHW'(i))) begin
        div_d[i] = bus.cfg_div;
        cnt_d[i] = '0;
      end else if (!bus.gate_mask[i] || (bus.mode == 2'b00)) begin
        ce_d[i]  = tc[i];
        sq_d[i]  = sq_q[i] ^ tc[i];
        cnt_d[i] = tc[i] ? '0 : cnt_q[i] + 1'b1;
      end else if ((bus.mode == 2'b10) && step_edge) begin
        ce_d[i]    = 1'b1;
        sq_d[i]    = ~sq_q[i];
        cnt_d[i]   = '0;
        stepped[i] = 1'b1;
      end
    end
    step_done_d = |stepped;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= CW'(DIV_RST);
      end
      ce_q        <= '0;
      sq_q        <= '0;
      step_done_q <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      ce_q        <= ce_d;
      sq_q        <= sq_d;
      step_done_q <= step_done_d;
      step_q      <= bus.step_req;
    end
  end

  assign bus.ce        = ce_q;
  assign bus.sq        = sq_q;
  assign bus.step_done = step_done_q;

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed plus randomized bench for clkgen_multi against a cycle-level model.
module tb_clkgen_multi;
  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int CHW = 3;
  localparam int DRS = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clkgen_multi_if #(.NCH(NCH), .CW(CW), .CHW(CHW)) bus ();

  clkgen_multi #(.NCH(NCH), .CW(CW), .DIV_RST(DRS), .CHW(CHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int             m_cnt [NCH];
  int             m_div [NCH];
  logic [NCH-1:0] m_ce, m_sq;
  logic           m_sd, m_stepq;
  int             n_ce [NCH];
  int             n_sd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Next-state of the reference, from the inputs present before the edge.
  task automatic model_step();
    logic edge_now;
    edge_now = bus.step_req && !m_stepq;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0;
        m_div[i] = DRS;
      end
      m_ce = '0; m_sq = '0; m_sd = 1'b0; m_stepq = 1'b0;
    end else begin
      m_sd = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_ce[i] = 1'b0;
        if (bus.cfg_we && int'(bus.cfg_ch) == i) begin
          m_div[i] = int'(bus.cfg_div);
          m_cnt[i] = 0;
        end else if (!bus.gate_mask[i] || bus.mode == 2'b00) begin
          if (m_cnt[i] == m_div[i]) begin
            m_ce[i] = 1'b1; m_sq[i] = ~m_sq[i]; m_cnt[i] = 0;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end else if (bus.mode == 2'b10 && edge_now) begin
          m_ce[i] = 1'b1; m_sq[i] = ~m_sq[i]; m_cnt[i] = 0; m_sd = 1'b1;
        end
      end
      m_stepq = bus.step_req;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("ce", 32'(bus.ce), 32'(m_ce));
    chk("sq", 32'(bus.sq), 32'(m_sq));
    chk("step_done", 32'(bus.step_done), 32'(m_sd));
    for (int i = 0; i < NCH; i++) n_ce[i] += int'(bus.ce[i]);
    n_sd += int'(bus.step_done);
  endtask

  task automatic clr();
    for (int i = 0; i < NCH; i++) n_ce[i] = 0;
    n_sd = 0;
  endtask

  task automatic wr(input int ch, input int d);
    bus.cfg_we = 1'b1; bus.cfg_ch = CHW'(ch); bus.cfg_div = CW'(d);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0;
    bus.mode = 2'b00; bus.gate_mask = '0; bus.step_req = 1'b0;
    clr();
    tick(); tick();
    chk("rst_ce", 32'(bus.ce), 0);
    chk("rst_sq", 32'(bus.sq), 0);
    chk("rst_sd", 32'(bus.step_done), 0);

    // 1: D=0 everywhere after reset, then D=4 on channel 1
    rst = 1'b0;
    tick();
    chk("t1_first_ce", 32'(bus.ce), 32'hF);
    wr(1, 4);
    chk("t1_wr_ce1", 32'(bus.ce[1]), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_wait_ce1", 32'(bus.ce[1]), 0);
    end
    tick();
    chk("t1_5th_ce1", 32'(bus.ce[1]), 1);
    clr();
    for (int k = 0; k < 20; k++) tick();
    chk("t1_n_ce1", n_ce[1], 4);
    chk("t1_n_ce0", n_ce[0], 20);

    // 2: halt a gated channel mid-count
    wr(2, 9);
    bus.gate_mask = 4'b0100;
    clr();
    for (int k = 0; k < 23; k++) tick();
    chk("t2_run_ce2", n_ce[2], 2);
    bus.mode = 2'b01;
    clr();
    for (int k = 0; k < 10; k++) tick();
    chk("t2_halt_ce2", n_ce[2], 0);
    chk("t2_halt_ce0", n_ce[0], 10);
    bus.mode = 2'b00;
    clr();
    for (int k = 0; k < 6; k++) tick();
    chk("t2_resume_pre", n_ce[2], 0);
    tick();
    chk("t2_resume_ce2", 32'(bus.ce[2]), 1);

    // 3: single-step channel 0
    bus.mode = 2'b10; bus.gate_mask = 4'b0001;
    wr(0, 7);
    clr();
    bus.step_req = 1'b1;
    tick();
    chk("t3_step_ce0", 32'(bus.ce[0]), 1);
    chk("t3_step_sd", 32'(bus.step_done), 1);
    for (int k = 0; k < 4; k++) tick();
    chk("t3_hold_nce", n_ce[0], 1);
    chk("t3_hold_nsd", n_sd, 1);
    bus.step_req = 1'b0;
    tick();
    bus.step_req = 1'b1;
    tick();
    chk("t3_step2_ce0", 32'(bus.ce[0]), 1);
    chk("t3_step2_sd", 32'(bus.step_done), 1);
    bus.step_req = 1'b0; bus.mode = 2'b00;
    tick();
    bus.step_req = 1'b1;
    clr();
    tick();
    chk("t3_run_sd", n_sd, 0);
    bus.mode = 2'b10;
    tick();
    chk("t3_noremember_ce0", 32'(bus.ce[0]), 0);
    chk("t3_noremember_sd", 32'(bus.step_done), 0);

    // 4: write on terminal count, then an out-of-range write
    bus.mode = 2'b00; bus.gate_mask = '0;
    for (int k = 0; k < 20 && m_cnt[1] != m_div[1]; k++) tick();
    chk("t4_reach_tc", 32'(m_cnt[1] == m_div[1]), 1);
    wr(1, 3);
    chk("t4_wr_ce1", 32'(bus.ce[1]), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_wait_ce1", 32'(bus.ce[1]), 0);
    end
    tick();
    chk("t4_4th_ce1", 32'(bus.ce[1]), 1);
    clr();
    wr(5, 0);
    for (int k = 0; k < 7; k++) tick();
    chk("t4_bad_ch_ce1", n_ce[1], 2);

    // 5: reset during step mode with a channel mid-count
    wr(2, 9);
    for (int k = 0; k < 6; k++) tick();
    bus.mode = 2'b10; bus.gate_mask = 4'b0100;
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_ce", 32'(bus.ce), 0);
    chk("t5_rst_sq", 32'(bus.sq), 0);
    chk("t5_rst_sd", 32'(bus.step_done), 0);
    rst = 1'b0; bus.mode = 2'b00; bus.gate_mask = '0;
    tick();
    chk("t5_div_reset", 32'(bus.ce), 32'hF);

    // 6: maximum divisor for CW=4
    wr(3, 15);
    clr();
    for (int k = 0; k < 15; k++) tick();
    chk("t6_pre", n_ce[3], 0);
    tick();
    chk("t6_first", 32'(bus.ce[3]), 1);
    for (int k = 0; k < 16; k++) tick();
    chk("t6_n_ce3", n_ce[3], 2);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(7) == 0) bus.mode = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) bus.gate_mask = 4'($urandom);
      if ($urandom_range(2) == 0) bus.step_req = ~bus.step_req;
      bus.cfg_we  = ($urandom_range(11) == 0);
      bus.cfg_ch  = 3'($urandom_range(5));
      bus.cfg_div = 4'($urandom_range(15));
      tick();
    end
    bus.cfg_we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
